data_mem_resp: RTL

- Memory-side responder for the multi-cycle CPU's data/instruction memory port.
- Accepts the address/wren/data request produced by the CPU's memory-access stage. Performs the write or read on a 4096x16 word array after a fixed number of wait states. Returns read data with a one-cycle rvalid strobe.
- Provides a ready/busy handshake so the CPU sequencer can stall phases while the access completes.

---
 rtl/data_mem_resp.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Memory-side responder: latches one read/write request, inserts WAIT_CYC wait
// states, then performs the access on a 2**ADDR_W x DATA_W array.
module data_mem_resp #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] q,
    output logic              rvalid,
    output logic              wdone,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = (WAIT_CYC > 0) ? 3'(WAIT_CYC - 1) : 3'd0;

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wren_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   q_q;
    logic                rvalid_q;
    logic                wdone_q;
    logic                mem_we_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // Handshake: a request transfers on a rising edge where req && ready;
    // req seen while ready is low is dropped, the initiator must hold or re-issue it.
    assign ready     = (state_q == ST_IDLE);
    assign busy      = ~ready;
    assign q         = q_q;
    assign rvalid    = rvalid_q;
    assign wdone     = wdone_q;
    assign dbg_state = state_q;

    // Reset forces IDLE asynchronously, so an aborted write never reaches the array.
    assign mem_we_d = (state_q == ST_ACCESS) && wren_q;

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            wren_q   <= 1'b0;
            data_q   <= '0;
            q_q      <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= address;
                        wren_q  <= wren;
                        data_q  <= data;
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_ACCESS: begin
                    if (wren_q) begin
                        wdone_q <= 1'b1;
                    end else begin
                        q_q      <= mem[addr_q];
                        rvalid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
